// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID stall/flush sequencer for load-use hazards and EX-stage redirects
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        iInstr,
  input  logic               iIDEXMemRead,
  input  logic [4:0]         iIDEXRt,
  input  logic               iBranchTaken,
  output logic               dataStall,
  output logic               controlStall,
  output logic               oPCWrite,
  output logic               oIDEXFlush,
  output logic [COUNT_W-1:0] oStallCycles
);
  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;
  localparam logic [3:0] LC = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FC = 4'(FLUSH_CYCLES - 1);
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [COUNT_W-1:0] r_stall;
  logic               w_lu;
  logic               w_hold;
  logic               w_zero;
  // load-use: ID instruction reads the register the load in EX is about to write
  assign w_lu = iIDEXMemRead && iIDEXRt != 5'd0 &&
                (iIDEXRt == iInstr[25:21] || iIDEXRt == iInstr[20:16]) &&
                iInstr != 32'd0 && iInstr[31:26] != 6'h02 && iInstr[31:26] != 6'h03;
  // Mealy outputs: a redirect beats any hold, reset forces a hold with bubble
  always_comb begin
    w_hold       = reset || (!iBranchTaken && (r_state == LSTALL || (r_state == RUN && w_lu)));
    w_zero       = !reset && (iBranchTaken || r_state == FLUSH);
    dataStall    = !w_hold;
    controlStall = !w_hold && !w_zero;
    oPCWrite     = !w_hold;
    oIDEXFlush   = w_hold || w_zero;
    oStallCycles = r_stall;
  end
  // state sequencing and saturating count of non-advance cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
      r_stall <= '0;
    end else begin
      if (!(dataStall && controlStall) && r_stall != '1)
        r_stall <= r_stall + {{(COUNT_W-1){1'b0}}, 1'b1};
      if (iBranchTaken) begin
        r_state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
        r_cnt   <= FC;
      end else if (r_state != RUN) begin
        r_state <= r_cnt == 4'd1 ? RUN : r_state;
        r_cnt   <= r_cnt - 4'd1;
      end else if (w_lu) begin
        r_state <= LOAD_STALL_CYCLES > 1 ? LSTALL : RUN;
        r_cnt   <= LC;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three parameterisations driven in lockstep against a cycle-count model
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mr = 1'b0;
  logic [4:0]  rt = 5'd0;
  logic        br = 1'b0;
  logic        ds [3];
  logic        cs [3];
  logic        pw [3];
  logic        fl [3];
  logic [15:0] sc [3];
  logic [15:0] sc0, sc2;
  logic [3:0]  sc1;
  int checks = 0, failures = 0;
  bit go = 0;
  int lp [3] = '{1, 3, 3};
  int fp [3] = '{2, 1, 3};
  int mx [3] = '{65535, 15, 65535};
  int mode [3] = '{0, 0, 0};
  int left [3] = '{0, 0, 0};
  int cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .COUNT_W(16)) d0 (
    .clk(clk), .reset(reset), .iInstr(instr), .iIDEXMemRead(mr), .iIDEXRt(rt), .iBranchTaken(br),
    .dataStall(ds[0]), .controlStall(cs[0]), .oPCWrite(pw[0]), .oIDEXFlush(fl[0]), .oStallCycles(sc0));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .COUNT_W(4)) d1 (
    .clk(clk), .reset(reset), .iInstr(instr), .iIDEXMemRead(mr), .iIDEXRt(rt), .iBranchTaken(br),
    .dataStall(ds[1]), .controlStall(cs[1]), .oPCWrite(pw[1]), .oIDEXFlush(fl[1]), .oStallCycles(sc1));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .COUNT_W(16)) d2 (
    .clk(clk), .reset(reset), .iInstr(instr), .iIDEXMemRead(mr), .iIDEXRt(rt), .iBranchTaken(br),
    .dataStall(ds[2]), .controlStall(cs[2]), .oPCWrite(pw[2]), .oIDEXFlush(fl[2]), .oStallCycles(sc2));

  assign sc[0] = sc0;
  assign sc[1] = {12'd0, sc1};
  assign sc[2] = sc2;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s d%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return mr && rt != 0 && (rt == instr[25:21] || rt == instr[20:16]) && instr != 0 &&
           instr[31:26] != 6'h02 && instr[31:26] != 6'h03;
  endfunction

  // model: mode 0 = flowing, 1 = holding, 2 = flushing; left = extra stall cycles still owed
  always @(negedge clk) begin
    if (go) begin
      for (int k = 0; k < 3; k++) begin
        int ep, epw, efl;
        if (reset) begin ep = 0; epw = 0; efl = 1; end
        else if (br || mode[k] == 2) begin ep = 2; epw = 1; efl = 1; end
        else if (mode[k] == 1 || hazard()) begin ep = 0; epw = 0; efl = 1; end
        else begin ep = 3; epw = 1; efl = 0; end
        chk("pair", k, int'({ds[k], cs[k]}), ep);
        chk("pcwrite", k, int'(pw[k]), epw);
        chk("idexflush", k, int'(fl[k]), efl);
        chk("stallcycles", k, int'(sc[k]), cnt[k]);
        if (reset) begin
          mode[k] = 0; left[k] = 0; cnt[k] = 0;
        end else begin
          if (ep != 3 && cnt[k] < mx[k]) cnt[k]++;
          if (br) begin
            left[k] = fp[k] - 1; mode[k] = left[k] > 0 ? 2 : 0;
          end else if (mode[k] != 0) begin
            left[k]--; if (left[k] == 0) mode[k] = 0;
          end else if (hazard()) begin
            left[k] = lp[k] - 1; mode[k] = left[k] > 0 ? 1 : 0;
          end
        end
      end
    end
  end

  task automatic drive(input bit r, input logic [31:0] i, input bit m, input logic [4:0] t, input bit b);
    @(posedge clk);
    #1 reset = r; instr = i; mr = m; rt = t; br = b;
    go = 1;
    #2;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 32'd0, 0, 5'd0, 0);
  endtask

  localparam logic [31:0] ADD = 32'h01095020;

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("rst_pair", 0, int'({ds[0], cs[0]}), 0);
    chk("rst_pcw", 0, int'(pw[0]), 0);
    chk("rst_flush", 0, int'(fl[0]), 1);
    idle(1);
    chk("run_pair", 0, int'({ds[0], cs[0]}), 3);
    chk("run_pcw", 0, int'(pw[0]), 1);
    chk("run_flush", 0, int'(fl[0]), 0);
    chk("run_cnt", 0, int'(sc[0]), 0);
    drive(0, ADD, 1, 5'd8, 0);
    chk("lu_pair", 0, int'({ds[0], cs[0]}), 0);
    chk("lu_pcw", 0, int'(pw[0]), 0);
    chk("lu_flush", 0, int'(fl[0]), 1);
    drive(0, ADD, 0, 5'd8, 0);
    chk("lu_after_pair", 0, int'({ds[0], cs[0]}), 3);
    chk("lu_after_cnt", 0, int'(sc[0]), 1);
    drive(0, ADD, 1, 5'd0, 0);
    chk("rt0_pair", 0, int'({ds[0], cs[0]}), 3);
    drive(0, 32'h09000010, 1, 5'd8, 0);
    chk("jump_pair", 0, int'({ds[0], cs[0]}), 3);
    idle(4);
    drive(0, 0, 0, 0, 1);
    chk("br1_pair", 0, int'({ds[0], cs[0]}), 2);
    chk("br1_pcw", 0, int'(pw[0]), 1);
    idle(1);
    chk("br2_pair", 0, int'({ds[0], cs[0]}), 2);
    chk("br2_pcw", 0, int'(pw[0]), 1);
    idle(1);
    chk("br3_pair", 0, int'({ds[0], cs[0]}), 3);
    chk("br_cnt", 0, int'(sc[0]), 3);
    idle(4);
    drive(0, ADD, 1, 5'd8, 1);
    chk("both_pair", 2, int'({ds[2], cs[2]}), 2);
    chk("both_pair", 1, int'({ds[1], cs[1]}), 2);
    idle(1);
    chk("both_fl1", 2, int'({ds[2], cs[2]}), 2);
    chk("both_nohold", 1, int'({ds[1], cs[1]}), 3);
    idle(1);
    chk("both_fl2", 2, int'({ds[2], cs[2]}), 2);
    idle(1);
    chk("both_done", 2, int'({ds[2], cs[2]}), 3);
    idle(4);
    drive(0, ADD, 1, 5'd8, 0);
    chk("ls1_pair", 1, int'({ds[1], cs[1]}), 0);
    drive(1, ADD, 0, 5'd8, 0);
    chk("ls_rst_pair", 1, int'({ds[1], cs[1]}), 0);
    chk("ls_rst_pcw", 1, int'(pw[1]), 0);
    chk("ls_rst_flush", 1, int'(fl[1]), 1);
    idle(1);
    chk("ls_after_pair", 1, int'({ds[1], cs[1]}), 3);
    chk("ls_after_cnt", 1, int'(sc[1]), 0);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[25:21] = 5'($urandom_range(0, 3));
      ri[20:16] = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ri = 32'd0;
        1: ri[31:26] = 6'h02;
        2: ri[31:26] = 6'h03;
        default: ri[31:26] = 6'h00;
      endcase
      drive($urandom_range(0, 63) == 0, ri, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end
    drive(1, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) drive(0, ADD, 1, 5'd8, 0);
    idle(1);
    chk("sat_cnt", 1, int'(sc[1]), 15);
    chk("sat_cnt", 0, int'(sc[0]), 20);
    @(negedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/stall controller for the 5-stage MIPS pipeline.
- Drives the IF/ID pipeline-register control pair (dataStall, controlStall), the PC write enable and the ID/EX bubble insert.
- Detects load-use hazards against the instruction held in IF/ID and branch/jump redirects resolved in EX.
- Sequences multi-cycle stalls and flushes, and keeps a saturating stall-cycle counter.

Parameters:
- LOAD_STALL_CYCLES, 1, hold cycles per load-use hazard (1..15).
- FLUSH_CYCLES, 1, IF/ID flush cycles per taken redirect (1..15).
- COUNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- iInstr  input  32  instruction currently in IF/ID (ID stage).
- iIDEXMemRead  input  1  instruction in ID/EX is a load.
- iIDEXRt  input  5  destination register of that load.
- iBranchTaken  input  1  EX-stage branch/jump redirect this cycle.
- dataStall  output  1  IF/ID control bit, MSB of the pair.
- controlStall  output  1  IF/ID control bit, LSB of the pair.
- oPCWrite  output  1  PC register load enable.
- oIDEXFlush  output  1  zero the ID/EX register next edge.
- oStallCycles  output  COUNT_W  saturating count of non-advance cycles.

Behaviour:
- IF/ID encoding for {dataStall, controlStall}:
  - 2'b11 = ADVANCE: load the inputs.
  - 2'b10 = FLUSH: load zeros.
  - 2'b00 = HOLD: keep contents.
  - The block never drives 2'b01.
- Outputs are Mealy: combinational from the registered state/count plus the current inputs. Zero-cycle reaction to a hazard.
- Load-use hazard (combinational), rs = iInstr[25:21], rt = iInstr[20:16]. Asserted when all of:
  - iIDEXMemRead = 1;
  - iIDEXRt != 0;
  - iIDEXRt equals rs or rt;
  - iInstr != 0 and opcode iInstr[31:26] is not 6'h02 / 6'h03.
- States: RUN, LSTALL, FLUSH. One 4-bit down-counter cnt is shared by LSTALL and FLUSH.
- RUN, priority order:
  1. iBranchTaken: outputs FLUSH pair, oPCWrite=1 (target), oIDEXFlush=1. Next state is FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  2. Load-use: outputs HOLD pair, oPCWrite=0, oIDEXFlush=1. Next state is LSTALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
  3. Otherwise: ADVANCE pair, oPCWrite=1, oIDEXFlush=0.
- LSTALL:
  - Outputs HOLD, oPCWrite=0, oIDEXFlush=1.
  - cnt decrements; when cnt reaches 1 → RUN next.
  - iBranchTaken in LSTALL aborts the stall and acts exactly as the RUN branch case.
- FLUSH:
  - Outputs FLUSH pair, oPCWrite=1, oIDEXFlush=1.
  - cnt decrements; cnt=1 → RUN next.
  - Load-use is ignored in FLUSH (IF/ID is being zeroed).
  - iBranchTaken in FLUSH reloads cnt=FLUSH_CYCLES-1 (with FLUSH_CYCLES=1 → RUN).
- oStallCycles:
  - +1 on each clk edge where the driven pair != 2'b11.
  - Saturates at all-ones with no wrap.
  - Not cleared by leaving a stall.
- Reset (synchronous, sampled on the clk edge):
  - State=RUN, cnt=0, oStallCycles=0.
  - While reset is high, outputs are forced to pair 2'b00, oPCWrite=0, oIDEXFlush=1. No counting during reset.
- Reset mid-stall/mid-flush: the sequence is abandoned; the first cycle after reset deasserts is RUN.
- Simultaneous iBranchTaken and load-use: the branch wins and no LSTALL is entered.

Test Plan:
- Reset held 2 cycles, then released with iInstr=32'h00000000, iIDEXMemRead=0 → pair 11, oPCWrite=1, oIDEXFlush=0, oStallCycles=0.
- iIDEXMemRead=1, iIDEXRt=5'd8, iInstr=32'h01095020 (add $10,$8,$9), LOAD_STALL_CYCLES=1:
  - that cycle: pair 00, oPCWrite=0, oIDEXFlush=1;
  - next cycle with iIDEXMemRead=0: pair 11;
  - oStallCycles=1.
- Same hazard with iIDEXRt=5'd0, or iInstr=32'h08000010 (j) → pair stays 11, no stall.
- FLUSH_CYCLES=2, iBranchTaken pulse 1 cycle → pair 10 for 2 cycles with oPCWrite=1, then 11; oStallCycles=2.
- Load-use and iBranchTaken together, LOAD_STALL_CYCLES=3 → pair 10 (branch wins), FLUSH entered, never HOLD.
- LOAD_STALL_CYCLES=3: assert reset in the 2nd stall cycle → outputs 00/0/1 during reset, RUN with pair 11 after. With COUNT_W=4 and a 20-cycle forced stall, oStallCycles saturates at 4'hF.
